// File: rtl/mul_arbiter.sv
// Two-requester front end for one shared pipelined multiplier: round-robin issue,
// a tag pipeline matching the multiplier latency, and a credit-limited result FIFO per requester.
module mul_arbiter #(
    parameter int WIDTH   = 32,
    parameter int LATENCY = 4,
    parameter int DEPTH   = 4
) (
    input  logic               clk,
    input  logic               rst_n,

    input  logic               req0_valid,
    output logic               req0_ready,
    input  logic [WIDTH-1:0]   req0_a,
    input  logic [WIDTH-1:0]   req0_b,

    input  logic               req1_valid,
    output logic               req1_ready,
    input  logic [WIDTH-1:0]   req1_a,
    input  logic [WIDTH-1:0]   req1_b,

    output logic               res0_valid,
    input  logic               res0_ready,
    output logic [2*WIDTH-1:0] res0_p,

    output logic               res1_valid,
    input  logic               res1_ready,
    output logic [2*WIDTH-1:0] res1_p,

    output logic [WIDTH-1:0]   mul_a,
    output logic [WIDTH-1:0]   mul_b,
    output logic               mul_valid,
    input  logic [2*WIDTH-1:0] mul_p,

    output logic               busy
);

    localparam int PW = 2 * WIDTH;
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [1:0]       req_valid;
    logic [1:0]       res_ready;
    logic [1:0]       eligible;
    logic [1:0]       cand;
    logic [1:0]       grant;
    logic [1:0]       push;
    logic [1:0]       pop;
    logic             accept;
    logic             win;
    logic             last_grant;

    logic [WIDTH-1:0] op_a [2];
    logic [WIDTH-1:0] op_b [2];

    logic [LATENCY-1:0] tag_vld;
    logic [LATENCY-1:0] tag_id;
    logic               wb_vld;
    logic               wb_id;

    logic [CW-1:0]    inflight [2];
    logic [CW-1:0]    count    [2];
    logic [AW-1:0]    wr_ptr   [2];
    logic [AW-1:0]    rd_ptr   [2];
    logic [PW-1:0]    mem      [2][DEPTH];

    assign req_valid = {req1_valid, req0_valid};
    assign res_ready = {res1_ready, res0_ready};
    assign op_a[0]   = req0_a;
    assign op_a[1]   = req1_a;
    assign op_b[0]   = req0_b;
    assign op_b[1]   = req1_b;

    // Credits count both in-flight operations and buffered results, so a FIFO can never overflow.
    always_comb begin
        eligible = '0;
        for (int i = 0; i < 2; i++) begin
            eligible[i] = ({1'b0, inflight[i]} + {1'b0, count[i]}) < (CW+1)'(DEPTH);
        end
    end

    always_comb begin
        grant = '0;
        cand  = req_valid & eligible;
        if (rst_n) begin
            if (cand == 2'b11) begin
                grant = last_grant ? 2'b01 : 2'b10;
            end else begin
                grant = cand;
            end
        end
    end

    assign req0_ready = grant[0];
    assign req1_ready = grant[1];
    assign accept     = |grant;
    assign win        = grant[1];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mul_valid  <= 1'b0;
            mul_a      <= '0;
            mul_b      <= '0;
            last_grant <= 1'b1;
        end else begin
            mul_valid <= accept;
            if (accept) begin
                mul_a      <= win ? op_a[1] : op_a[0];
                mul_b      <= win ? op_b[1] : op_b[0];
                last_grant <= win;
            end
        end
    end

    // Tag pipeline: stage k holds the issue made k+1 edges ago; the last stage meets mul_p.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tag_vld <= '0;
            tag_id  <= '0;
        end else begin
            tag_vld[0] <= accept;
            tag_id[0]  <= win;
            for (int k = 1; k < LATENCY; k++) begin
                tag_vld[k] <= tag_vld[k-1];
                tag_id[k]  <= tag_id[k-1];
            end
        end
    end

    assign wb_vld = tag_vld[LATENCY-1];
    assign wb_id  = tag_id[LATENCY-1];

    always_comb begin
        push = '0;
        pop  = '0;
        for (int i = 0; i < 2; i++) begin
            push[i] = wb_vld && (wb_id == 1'(i));
            pop[i]  = res_ready[i] && (count[i] != '0);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 2; i++) begin
                inflight[i] <= '0;
                count[i]    <= '0;
                wr_ptr[i]   <= '0;
                rd_ptr[i]   <= '0;
            end
        end else begin
            for (int i = 0; i < 2; i++) begin
                case ({grant[i], push[i]})
                    2'b10:   inflight[i] <= inflight[i] + CW'(1);
                    2'b01:   inflight[i] <= inflight[i] - CW'(1);
                    default: inflight[i] <= inflight[i];
                endcase
                case ({push[i], pop[i]})
                    2'b10:   count[i] <= count[i] + CW'(1);
                    2'b01:   count[i] <= count[i] - CW'(1);
                    default: count[i] <= count[i];
                endcase
                if (push[i]) begin
                    wr_ptr[i] <= wr_ptr[i] + AW'(1);
                end
                if (pop[i]) begin
                    rd_ptr[i] <= rd_ptr[i] + AW'(1);
                end
            end
        end
    end

    // Storage is not reset; the count gates everything read out of it.
    always_ff @(posedge clk) begin
        for (int i = 0; i < 2; i++) begin
            if (push[i]) begin
                mem[i][wr_ptr[i]] <= mul_p;
            end
        end
    end

    assign res0_valid = (count[0] != '0);
    assign res1_valid = (count[1] != '0);
    assign res0_p     = res0_valid ? mem[0][rd_ptr[0]] : '0;
    assign res1_p     = res1_valid ? mem[1][rd_ptr[1]] : '0;
    assign busy       = (|tag_vld) | res0_valid | res1_valid;

endmodule

// File: tb/tb_mul_arbiter.sv
// Bench for mul_arbiter: directed product table, contention, backpressure, credit release,
// mid-flight reset and a randomized scoreboard run against a behavioural pipelined multiplier.
module tb_mul_arbiter;

    localparam int W   = 32;
    localparam int LAT = 4;
    localparam int DEP = 8;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          req0_valid, req0_ready, req1_valid, req1_ready;
    logic [W-1:0]  req0_a, req0_b, req1_a, req1_b;
    logic          res0_valid, res0_ready, res1_valid, res1_ready;
    logic [2*W-1:0] res0_p, res1_p;
    logic [W-1:0]  mul_a, mul_b;
    logic          mul_valid;
    logic [2*W-1:0] mul_p;
    logic          busy;

    mul_arbiter #(.WIDTH(W), .LATENCY(LAT), .DEPTH(DEP)) dut (
        .clk(clk), .rst_n(rst_n),
        .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_a(req0_a), .req0_b(req0_b),
        .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_a(req1_a), .req1_b(req1_b),
        .res0_valid(res0_valid), .res0_ready(res0_ready), .res0_p(res0_p),
        .res1_valid(res1_valid), .res1_ready(res1_ready), .res1_p(res1_p),
        .mul_a(mul_a), .mul_b(mul_b), .mul_valid(mul_valid), .mul_p(mul_p),
        .busy(busy)
    );

    always #5 clk = ~clk;

    // Shared multiplier: product of the issue cycle is presented LAT cycles later.
    logic [2*W-1:0] mpipe [LAT-1];
    always @(posedge clk) begin
        mpipe[0] <= {32'b0, mul_a} * {32'b0, mul_b};
        for (int k = 1; k < LAT - 1; k++) mpipe[k] <= mpipe[k-1];
    end
    assign mul_p = mpipe[LAT-2];

    int total = 0;
    int bad   = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: actual=%0h required=%0h", name, act, req);
        end
    endtask

    // Scoreboard, sampled mid-cycle on what will transfer at the next rising edge.
    logic [63:0] exp0[$], exp1[$];
    int          acc0, acc1, pops0, pops1;
    logic [63:0] last0, last1;
    bit          sb_on = 1'b0;

    initial begin
        forever begin
            @(negedge clk);
            if (sb_on && rst_n) begin
                if (req0_valid && req0_ready) begin exp0.push_back({32'b0, req0_a} * {32'b0, req0_b}); acc0++; end
                if (req1_valid && req1_ready) begin exp1.push_back({32'b0, req1_a} * {32'b0, req1_b}); acc1++; end
                if (res0_valid && res0_ready) begin
                    pops0++; last0 = res0_p;
                    if (exp0.size() == 0) begin total++; bad++; $display("FAIL sb0_extra: actual=%0h required=none", res0_p); end
                    else check("sb0_order", res0_p, exp0.pop_front());
                end
                if (res1_valid && res1_ready) begin
                    pops1++; last1 = res1_p;
                    if (exp1.size() == 0) begin total++; bad++; $display("FAIL sb1_extra: actual=%0h required=none", res1_p); end
                    else check("sb1_order", res1_p, exp1.pop_front());
                end
            end
        end
    end

    initial begin
        #600000;
        $display("FAIL watchdog: actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    typedef struct {
        bit          id;
        logic [31:0] a;
        logic [31:0] b;
        logic [63:0] p;
    } vec_t;
    vec_t vecs [8];

    task automatic set_req(input bit id, input logic v, input logic [31:0] a, input logic [31:0] b);
        if (!id) begin req0_valid = v; req0_a = a; req0_b = b; end
        else     begin req1_valid = v; req1_a = a; req1_b = b; end
    endtask

    function automatic logic get_ready(input bit id);
        return id ? req1_ready : req0_ready;
    endfunction

    function automatic logic get_resv(input bit id);
        return id ? res1_valid : res0_valid;
    endfunction

    function automatic logic [63:0] get_resp(input bit id);
        return id ? res1_p : res0_p;
    endfunction

    task automatic do_reset();
        sb_on = 1'b0;
        req0_valid = 0; req1_valid = 0; res0_ready = 0; res1_ready = 0;
        req0_a = 0; req0_b = 0; req1_a = 0; req1_b = 0;
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        exp0.delete(); exp1.delete();
        acc0 = 0; acc1 = 0; pops0 = 0; pops1 = 0; last0 = 0; last1 = 0;
    endtask

    task automatic wait_idle(input string name);
        int n = 0;
        @(negedge clk);
        while (busy && n < 300) begin @(negedge clk); n++; end
        total++;
        if (busy) begin bad++; $display("FAIL %s: actual=busy required=idle", name); end
    endtask

    task automatic run_vec(input vec_t v);
        @(posedge clk); #1;
        set_req(v.id, 1'b1, v.a, v.b);
        @(negedge clk);
        check("vec_ready", get_ready(v.id), 1);
        check("vec_other_ready", get_ready(!v.id), 0);
        @(posedge clk); #1;
        set_req(v.id, 1'b0, 0, 0);
        check("vec_mul_valid", mul_valid, 1);
        check("vec_mul_a", mul_a, v.a);
        check("vec_mul_b", mul_b, v.b);
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("vec_early_res_valid", get_resv(v.id), 0);
        check("vec_mul_valid_low", mul_valid, 0);
        @(negedge clk);
        check("vec_res_valid", get_resv(v.id), 1);
        check("vec_product", get_resp(v.id), v.p);
        check("vec_other_res_valid", get_resv(!v.id), 0);
        check("vec_busy", busy, 1);
        if (!v.id) res0_ready = 1; else res1_ready = 1;
        @(posedge clk); #1;
        res0_ready = 0; res1_ready = 0;
        check("vec_res_valid_after_pop", get_resv(v.id), 0);
        check("vec_busy_after_pop", busy, 0);
    endtask

    initial begin
        bit g0, g1, a0, a1;
        int r1_hi, r0_late;

        vecs[0] = '{1'b0, 32'd3,         32'd3,         64'd9};
        vecs[1] = '{1'b1, 32'hFFFFFFFF,  32'hFFFFFFFF,  64'hFFFFFFFE_00000001};
        vecs[2] = '{1'b0, 32'h00010000,  32'h00010000,  64'h00000001_00000000};
        vecs[3] = '{1'b1, 32'h0,         32'h12345678,  64'h0};
        vecs[4] = '{1'b0, 32'hFFFFFFFF,  32'd2,         64'h00000001_FFFFFFFE};
        vecs[5] = '{1'b1, 32'h12345678,  32'h10,        64'h00000001_23456780};
        vecs[6] = '{1'b0, 32'h80000000,  32'h80000000,  64'h40000000_00000000};
        vecs[7] = '{1'b1, 32'd7,         32'd6,         64'h2A};

        // Outputs held low while reset is asserted, even with requests pending.
        rst_n = 1'b0;
        req0_valid = 1; req1_valid = 1; req0_a = 5; req0_b = 6; req1_a = 7; req1_b = 8;
        res0_ready = 1; res1_ready = 1;
        #12;
        check("rst_req0_ready", req0_ready, 0);
        check("rst_req1_ready", req1_ready, 0);
        check("rst_res0_valid", res0_valid, 0);
        check("rst_res1_valid", res1_valid, 0);
        check("rst_mul_valid", mul_valid, 0);
        check("rst_mul_a", mul_a, 0);
        check("rst_res0_p", res0_p, 0);
        check("rst_busy", busy, 0);

        do_reset();
        for (int i = 0; i < 8; i++) run_vec(vecs[i]);

        // Contention: both requesters always valid, requester 0 wins first.
        do_reset();
        sb_on = 1'b1;
        @(posedge clk); #1;
        set_req(0, 1, 32'hFFFFFFFF, 32'hFFFFFFFF);
        set_req(1, 1, 32'hFFFFFFFF, 32'hFFFFFFFF);
        res0_ready = 1; res1_ready = 1;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            check("cont_ready0", req0_ready, (k % 2) == 0);
            check("cont_ready1", req1_ready, (k % 2) == 1);
            @(posedge clk); #1;
        end
        req0_valid = 0; req1_valid = 0;
        wait_idle("cont_drain");
        check("cont_pops0", pops0, 4);
        check("cont_pops1", pops1, 4);
        check("cont_last0", last0, 64'hFFFFFFFE_00000001);
        check("cont_last1", last1, 64'hFFFFFFFE_00000001);

        // Backpressure on port 0 while port 1 keeps draining.
        do_reset();
        sb_on = 1'b1;
        @(posedge clk); #1;
        set_req(0, 1, 32'd1, 32'd100);
        set_req(1, 1, 32'd2, 32'd200);
        res0_ready = 0; res1_ready = 1;
        r1_hi = 0; r0_late = 0;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            g0 = req0_ready; g1 = req1_ready;
            if (k >= 30) begin r1_hi += int'(g1); r0_late += int'(g0); end
            @(posedge clk); #1;
            if (g0) begin req0_a = req0_a + 1; req0_b = req0_b + 3; end
            if (g1) begin req1_a = req1_a + 5; req1_b = req1_b + 1; end
        end
        check("bp_accepts0", acc0, DEP);
        check("bp_req1_every_cycle", r1_hi, 10);
        check("bp_req0_blocked", r0_late, 0);

        // Credit release: one pop from a full FIFO frees a slot only on the next cycle.
        req1_valid = 0;
        repeat (8) @(posedge clk);
        #1;
        check("cr_full_ready0", req0_ready, 0);
        check("cr_full_res0_valid", res0_valid, 1);
        res0_ready = 1;
        #1;
        check("cr_same_cycle_ready0", req0_ready, 0);
        @(posedge clk); #1;
        res0_ready = 0;
        check("cr_ready0_after_pop", req0_ready, 1);
        @(posedge clk); #1;
        req0_valid = 0;
        check("cr_accepts0", acc0, DEP + 1);
        res0_ready = 1; res1_ready = 1;
        wait_idle("cr_drain");
        check("cr_pops0", pops0, DEP + 1);
        check("cr_exp0_empty", exp0.size(), 0);
        check("cr_pops1", pops1, acc1);

        // Reset in the middle of traffic discards everything.
        do_reset();
        @(posedge clk); #1; set_req(0, 1, 32'd5, 32'd7);
        @(posedge clk); #1; set_req(0, 1, 32'd6, 32'd7);
        @(posedge clk); #1; set_req(0, 1, 32'd8, 32'd9);
        @(posedge clk); #1; set_req(0, 0, 0, 0);
        @(posedge clk);
        @(posedge clk); #1;
        check("mid_pre_res0_valid", res0_valid, 1);
        check("mid_pre_res0_p", res0_p, 64'd35);
        set_req(0, 1, 32'd11, 32'd13);
        set_req(1, 1, 32'd3, 32'd4);
        @(posedge clk); #1;
        rst_n = 1'b0;
        #1;
        check("mid_req0_ready", req0_ready, 0);
        check("mid_req1_ready", req1_ready, 0);
        check("mid_res0_valid", res0_valid, 0);
        check("mid_res0_p", res0_p, 0);
        check("mid_mul_valid", mul_valid, 0);
        check("mid_mul_a", mul_a, 0);
        check("mid_mul_b", mul_b, 0);
        check("mid_busy", busy, 0);
        repeat (2) @(posedge clk);
        #1;
        set_req(0, 0, 0, 0); set_req(1, 0, 0, 0);
        res0_ready = 0; res1_ready = 0;
        rst_n = 1'b1;
        for (int k = 0; k < LAT + 2; k++) begin
            @(negedge clk);
            check("mid_stale_res0", res0_valid, 0);
            check("mid_stale_res1", res1_valid, 0);
        end
        check("mid_busy_after", busy, 0);

        // Random traffic against the scoreboard.
        do_reset();
        sb_on = 1'b1;
        for (int c = 0; c < 10000; c++) begin
            @(negedge clk);
            a0 = req0_valid && req0_ready;
            a1 = req1_valid && req1_ready;
            @(posedge clk); #1;
            if (!req0_valid || a0) begin
                req0_valid = 1'($urandom_range(0, 1));
                req0_a = ($urandom_range(0, 3) == 0) ? 32'hFFFFFFFF : $urandom;
                req0_b = ($urandom_range(0, 3) == 0) ? 32'hFFFFFFFF : $urandom;
            end
            if (!req1_valid || a1) begin
                req1_valid = 1'($urandom_range(0, 1));
                req1_a = ($urandom_range(0, 3) == 0) ? 32'h0 : $urandom;
                req1_b = $urandom;
            end
            res0_ready = ($urandom_range(0, 9) < ((((c / 256) % 2) == 1) ? 2 : 8));
            res1_ready = ($urandom_range(0, 9) < ((((c / 300) % 2) == 1) ? 8 : 3));
        end
        req0_valid = 0; req1_valid = 0;
        res0_ready = 1; res1_ready = 1;
        wait_idle("rand_drain");
        check("rand_count0", pops0, acc0);
        check("rand_count1", pops1, acc1);
        check("rand_exp0_empty", exp0.size(), 0);
        check("rand_exp1_empty", exp1.size(), 0);
        sb_on = 1'b0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
